// File: rtl/mdu32.sv
// mdu32: iterative RV32M multiply/divide unit.
// One 64-bit shift register serves both shift-add multiply (LSB first) and
// restoring division (MSB first). Accept -> 32 CALC cycles -> 1 SIGN cycle ->
// DONE, so the result is registered 33 cycles after acceptance.
module mdu32 #(
    parameter int OP_W    = 6,
    parameter int OP_BASE = 38
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     src1,
    input  logic [31:0]     src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     result
);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    localparam logic [OP_W-1:0] LP_BASE = OP_W'(OP_BASE);
    localparam logic [OP_W-1:0] LP_MAXK = OP_W'(7);

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_result;
    logic [4:0]  r_cnt;
    logic [2:0]  r_k;
    logic        r_oob;
    logic        r_neg;
    logic        r_div0;
    logic        r_ovf;
    logic [31:0] r_src1;
    logic [31:0] r_b;
    logic [63:0] r_acc;

    // Decode of the incoming op and operand conditioning
    logic [OP_W-1:0] w_k_full;
    logic            w_oob;
    logic            w_signed1;
    logic            w_signed2;
    logic            w_s1;
    logic            w_s2;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic [31:0]     w_a_abs;
    logic [31:0]     w_b_abs;

    // Iteration datapath and final result selection
    logic [32:0]     w_sum;
    logic [32:0]     w_shift;
    logic [32:0]     w_diff;
    logic [63:0]     w_step;
    logic [63:0]     w_prod;
    logic [31:0]     w_quo;
    logic [31:0]     w_rem;
    logic [31:0]     w_result;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;

    // Decode op index, pick which operands are signed, build magnitudes and flags
    always_comb begin
        w_k_full  = op - LP_BASE;
        w_oob     = (op < LP_BASE) | (w_k_full > LP_MAXK);
        w_signed1 = 1'b0;
        w_signed2 = 1'b0;
        case (w_k_full[2:0])
            3'd0:    w_signed1 = 1'b1;
            3'd1:    begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
            3'd2:    w_signed1 = 1'b1;
            3'd4:    begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
            3'd6:    begin w_signed1 = 1'b1; w_signed2 = 1'b1; end
            default: ;
        endcase
        w_s1    = w_signed1 & src1[31];
        w_s2    = w_signed2 & src2[31];
        // 32-bit negate keeps 0x80000000 as 0x80000000 (correct unsigned magnitude)
        w_a_abs = w_s1 ? (~src1 + 32'd1) : src1;
        w_b_abs = w_s2 ? (~src2 + 32'd1) : src2;
        // Remainders take the dividend's sign; everything else takes sign1^sign2
        w_neg   = (w_k_full[2:1] == 2'b11) ? w_s1 : (w_s1 ^ w_s2);
        w_div0  = (src2 == 32'd0);
        w_ovf   = ((w_k_full[2:0] == 3'd4) || (w_k_full[2:0] == 3'd6)) &&
                  (src1 == 32'h8000_0000) && (src2 == 32'hFFFF_FFFF);
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        // Multiply: acc = {partial high, remaining multiplier bits}
        w_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
        // Divide: acc = {partial remainder, dividend bits / quotient bits}
        w_shift = {r_acc[63:32], r_acc[31]};
        // Partial remainder is below 2*divisor, so bit 32 of the difference is the borrow
        w_diff  = w_shift - {1'b0, r_b};
        if (r_k[2]) begin
            if (w_diff[32])
                w_step = {w_shift[31:0], r_acc[30:0], 1'b0};
            else
                w_step = {w_diff[31:0], r_acc[30:0], 1'b1};
        end else begin
            w_step = {w_sum, r_acc[31:1]};
        end
    end

    // Sign fix-up and result select, with div-by-zero / overflow overrides
    always_comb begin
        w_prod = r_neg ? (~r_acc + 64'd1) : r_acc;
        w_quo  = r_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
        w_rem  = r_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
        case (r_k)
            3'd0:       w_result = w_prod[31:0];
            3'd4, 3'd5: w_result = r_div0 ? 32'hFFFF_FFFF :
                                   (r_ovf ? 32'h8000_0000 : w_quo);
            3'd6, 3'd7: w_result = r_div0 ? r_src1 :
                                   (r_ovf ? 32'd0 : w_rem);
            default:    w_result = w_prod[63:32];
        endcase
        if (r_oob)
            w_result = 32'd0;
    end

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_cnt       <= 5'd0;
            r_k         <= 3'd0;
            r_oob       <= 1'b0;
            r_neg       <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_src1      <= 32'd0;
            r_b         <= 32'd0;
            r_acc       <= 64'd0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= CALC;
                        r_in_ready <= 1'b0;
                        r_cnt      <= 5'd0;
                        r_k        <= w_k_full[2:0];
                        r_oob      <= w_oob;
                        r_neg      <= w_neg;
                        r_div0     <= w_div0;
                        r_ovf      <= w_ovf;
                        r_src1     <= src1;
                        r_b        <= w_b_abs;
                        r_acc      <= {32'd0, w_a_abs};
                    end
                end
                CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31)
                        r_state <= SIGN;
                end
                SIGN: begin
                    r_result    <= w_result;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
